// File: rtl/apb_gen_capture_pkg.sv
// Register map and bit positions shared by the capture slave and its FIFO.
package apb_gen_capture_pkg;
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DATA   = 8'h08;
  localparam logic [7:0] ADDR_COUNT  = 8'h0C;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LEVEL = 8;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;
endpackage

// File: rtl/apb_gen_capture_sync_fifo.sv
// Sample FIFO with first-word-fall-through head; pointers carry an extra MSB
// so full and empty are distinguishable without a separate counter.
module sync_fifo
  import apb_gen_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_h,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  localparam int AW = LW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wptr_q;
  logic [LW-1:0]    rptr_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head    = mem_q[rptr_q[AW-1:0]];
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/apb_gen_capture.sv
// APB3 slave that runs the code generator, buffers its samples and reports
// status, sample count and a level interrupt to software.
module apb_gen_capture
  import apb_gen_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_h,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        gen_ena,
  input  logic [7:0]  gen_data,
  input  logic        gen_stop,
  output logic        irq
);
  localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

  logic        run_q, irq_en_q, done_q, ovf_q, irq_q;
  logic [15:0] count_q;
  logic        access, ctrl_wr, clr, pop, cap, fits;
  logic [7:0]  addr;
  logic [7:0]  head;
  logic [LW-1:0] level;
  logic        full, empty;
  logic [31:0] status;
  logic [31:0] rdata;
  logic        err;
  logic        unused_bits;

  assign unused_bits = ^{paddr[1:0], pwdata[31:3]};

  assign access  = psel & penable;
  assign addr    = {paddr[7:2], 2'b00};
  assign ctrl_wr = access & pwrite & (addr == ADDR_CTRL);
  assign clr     = ctrl_wr & pwdata[CTRL_CLR];
  assign pop     = access & ~pwrite & (addr == ADDR_DATA) & ~empty;
  assign cap     = run_q & ~gen_stop;
  assign fits    = ~full | pop;

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_DONE]  = done_q;
    status[ST_OVF]   = ovf_q;
    status[ST_LEVEL +: LW] = level;
  end

  // Errored accesses and writes return zero; only good reads drive data.
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    if (access) begin
      case (addr)
        ADDR_CTRL: begin
          if (!pwrite) begin
            rdata[CTRL_RUN]    = run_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
          end
        end
        ADDR_STATUS: if (pwrite) err = 1'b1; else rdata = status;
        ADDR_DATA:   if (pwrite || empty) err = 1'b1; else rdata = {24'd0, head};
        ADDR_COUNT:  if (pwrite) err = 1'b1; else rdata = {16'd0, count_q};
        default:     err = 1'b1;
      endcase
    end
  end

  assign prdata  = rdata;
  assign pslverr = err;
  assign pready  = 1'b1;
  assign gen_ena = run_q;
  assign irq     = irq_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst_h (rst_h),
    .push  (cap & ~clr),
    .pop   (pop),
    .flush (clr),
    .din   (gen_data),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      irq_q <= irq_en_q & (done_q | ovf_q | (level >= HALF));
      if (run_q && gen_stop) begin
        done_q <= 1'b1;
        run_q  <= 1'b0;
      end
      if (clr) begin
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
        count_q <= '0;
      end else if (cap) begin
        if (!fits) ovf_q <= 1'b1;
        else if (count_q != COUNT_MAX) count_q <= count_q + 16'd1;
      end
      // A software write overrides a coincident end-of-sequence.
      if (ctrl_wr) begin
        run_q    <= pwdata[CTRL_RUN];
        irq_en_q <= pwdata[CTRL_IRQ_EN];
        if (pwdata[CTRL_RUN]) done_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_gen_capture.sv
// Randomised bench for apb_gen_capture: a queue-based register model predicts
// every APB response and a negedge monitor checks them from a scoreboard.
module tb_apb_gen_capture;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic        clk = 1'b0;
  logic        rst_h = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, gen_ena, gen_stop, irq;
  logic [7:0]  gen_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_gen_capture #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst_h(rst_h), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gen_ena(gen_ena), .gen_data(gen_data),
    .gen_stop(gen_stop), .irq(irq)
  );

  // Generator: counts 0..255 while enabled, then flags stop; held at 0 when disabled.
  int unsigned gcnt = 0;
  always @(posedge clk) begin
    if (!gen_ena) gcnt <= 0;
    else if (gcnt < 256) gcnt <= gcnt + 1;
  end
  assign gen_data = gcnt[7:0];
  assign gen_stop = (gcnt == 256);

  // Reference model state
  byte unsigned mq[$];
  bit m_run, m_ien, m_done, m_ovf, m_irq;
  int m_cnt;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_ien = 0; m_done = 0; m_ovf = 0; m_irq = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit acc, ctrl_wr, clr, pop, cap;
    logic [7:0] a;
    acc     = psel && penable;
    a       = paddr & 8'hFC;
    ctrl_wr = acc && pwrite && (a == 8'h00);
    clr     = ctrl_wr && pwdata[1];
    pop     = acc && !pwrite && (a == 8'h08) && (mq.size() > 0);
    cap     = m_run && !gen_stop;
    m_irq   = m_ien && (m_done || m_ovf || (mq.size() >= DEPTH / 2));
    if (m_run && gen_stop) begin
      m_done = 1; m_run = 0;
    end
    if (clr) begin
      mq.delete(); m_done = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(gen_data);
          if (m_cnt < 65535) m_cnt++;
        end else m_ovf = 1;
      end
    end
    if (ctrl_wr) begin
      m_run = pwdata[0]; m_ien = pwdata[2];
      if (pwdata[0]) m_done = 0;
    end
  endtask

  always @(posedge clk or posedge rst_h) begin
    if (rst_h) model_reset();
    else model_step();
  end

  function automatic void expect_acc(input logic wr, input logic [7:0] ad,
                                     output logic [31:0] d, output logic e);
    logic [7:0] a;
    a = ad & 8'hFC;
    d = '0; e = 1'b0;
    case (a)
      8'h00: if (!wr) d = {29'd0, m_ien, 1'b0, m_run};
      8'h04: if (wr) e = 1'b1;
             else d = (32'(mq.size()) << 8) |
                      {28'd0, m_ovf, m_done, mq.size() == DEPTH, mq.size() == 0};
      8'h08: if (wr || mq.size() == 0) e = 1'b1; else d = 32'(mq[0]);
      8'h0C: if (wr) e = 1'b1; else d = 32'(m_cnt);
      default: e = 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [7:0]  a;
    logic        e;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every access phase, checks idle bus and side outputs.
  always @(negedge clk) begin
    exp_t x;
    if (psel && penable) begin
      if (exp_q.size() == 0) begin
        chk("apb_unexpected_access", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        $display("apb %s addr=%02h prdata=%08h pslverr=%0d", pwrite ? "wr" : "rd",
                 paddr, prdata, pslverr);
        chk($sformatf("prdata@%02h", x.a), prdata, x.d);
        chk($sformatf("pslverr@%02h", x.a), 32'(pslverr), 32'(x.e));
      end
    end else begin
      chk("idle_prdata", prdata, 32'd0);
      chk("idle_pslverr", 32'(pslverr), 32'd0);
    end
    chk("gen_ena", 32'(gen_ena), 32'(m_run));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("pready", 32'(pready), 32'd1);
  end

  task automatic apb(input logic wr, input logic [7:0] ad, input logic [31:0] wd);
    exp_t x;
    psel = 1; penable = 0; pwrite = wr; paddr = ad; pwdata = wd;
    @(posedge clk); #1;
    penable = 1;
    x.a = ad;
    expect_acc(wr, ad, x.d, x.e);
    exp_q.push_back(x);
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wd;
    int r;
    idle(3);
    chk("reset_gen_ena", 32'(gen_ena), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    rst_h = 0;
    idle(2);
    apb(0, 8'h04, 0);
    apb(0, 8'h0C, 0);

    // Fill and overflow with interrupts enabled, then pop against a full FIFO.
    apb(1, 8'h00, 32'h5);
    idle(30);
    apb(0, 8'h04, 0);
    apb(0, 8'h0C, 0);
    apb(0, 8'h08, 0);
    apb(0, 8'h04, 0);
    apb(0, 8'h0C, 0);
    for (int i = 0; i < 20; i++) apb(0, 8'h08, 0);
    idle(260);
    apb(0, 8'h04, 0);
    apb(0, 8'h00, 0);
    for (int i = 0; i < 20; i++) apb(0, 8'h08, 0);

    // Error paths: empty pop, write to RO, unmapped read.
    apb(0, 8'h08, 0);
    apb(1, 8'h04, 32'hFFFF_FFFF);
    apb(0, 8'h10, 0);
    apb(0, 8'h04, 0);

    // CLR+RUN while capturing.
    apb(1, 8'h00, 32'h1);
    idle(5);
    apb(1, 8'h00, 32'h3);
    apb(0, 8'h04, 0);
    apb(0, 8'h0C, 0);
    apb(0, 8'h08, 0);
    apb(0, 8'h08, 0);

    // Random traffic, including stray low address bits.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          wd = $urandom;
          wd[0] = ($urandom_range(0, 9) < 8);
          wd[1] = ($urandom_range(0, 11) == 0);
          apb(1, 8'(8'h00 | $urandom_range(0, 3)), wd);
        end
        2:    apb(0, 8'(8'h00 | $urandom_range(0, 3)), 0);
        3, 4: apb($urandom_range(0, 5) == 0, 8'(8'h04 | $urandom_range(0, 3)), $urandom);
        5, 6, 7: apb($urandom_range(0, 7) == 0, 8'(8'h08 | $urandom_range(0, 3)), $urandom);
        8:    apb(0, 8'(8'h0C | $urandom_range(0, 3)), 0);
        default: apb($urandom_range(0, 1), 8'($urandom_range(16, 255)), $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end

    // Asynchronous reset in the middle of a run with the interrupt raised.
    apb(1, 8'h00, 32'h5);
    idle(20);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    @(posedge clk); #3;
    rst_h = 1;
    #1;
    chk("async_gen_ena", 32'(gen_ena), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_prdata", prdata, 32'd0);
    chk("async_pslverr", 32'(pslverr), 32'd0);
    idle(2);
    rst_h = 0;
    idle(2);
    apb(0, 8'h04, 0);
    apb(0, 8'h0C, 0);
    apb(0, 8'h00, 0);
    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
